// File: rtl/seq_mul_pkg.sv
// Shared types and helpers for the iterative shift-add multiplier.
// The optional feature macro SEQMUL_EARLY_TERM_EN lives in seq_mul_ctrl.
package seq_mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Widest operand abs_mag can handle; callers sign-extend into this and truncate back.
    localparam int MAG_MAX_W = 64;

    function automatic logic [MAG_MAX_W-1:0] abs_mag(input logic [MAG_MAX_W-1:0] x,
                                                     input logic                 sgn);
        logic [MAG_MAX_W-1:0] mag_v;
        if (sgn && x[MAG_MAX_W-1]) begin
            mag_v = (~x) + {{(MAG_MAX_W-1){1'b0}}, 1'b1};
        end else begin
            mag_v = x;
        end
        return mag_v;
    endfunction

endpackage

// File: rtl/seq_mul_if.sv
// Operand/result handshake bundle between staging logic, multiplier and writeback.
interface seq_mul_if #(
    parameter int WIDTH = 32
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               is_signed;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] result;

    modport master (
        output in_valid, a, b, is_signed, out_ready,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  in_valid, a, b, is_signed, out_ready,
        output in_ready, out_valid, result
    );
endinterface

// File: rtl/seq_mul_ctrl.sv
// Sequencer: IDLE/RUN/DONE FSM, iteration counter, handshake flags, last-iteration decode.
// SEQMUL_EARLY_TERM_EN: also finish once no multiplier bits remain.
module seq_mul_ctrl
    import seq_mul_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    input  logic out_ready,
`ifdef SEQMUL_EARLY_TERM_EN
    input  logic rest_zero,
`endif
    output logic in_ready,
    output logic out_valid,
    output logic accept,
    output logic run,
    output logic last
);
    localparam int CNT_W = $clog2(WIDTH);

    state_e           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             in_ready_r;
    logic             out_valid_r;
    logic             early_s;

`ifdef SEQMUL_EARLY_TERM_EN
    assign early_s = rest_zero;
`else
    assign early_s = 1'b0;
`endif

    // Handshake and iteration-end decode from registered state.
    always_comb begin
        accept = in_valid & in_ready_r;
        run    = (state_r == RUN);
        last   = run & ((cnt_r == CNT_W'(WIDTH-1)) | early_s);
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;

    // Operation sequencing with registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept) begin
                        state_r    <= RUN;
                        cnt_r      <= {CNT_W{1'b0}};
                        in_ready_r <= 1'b0;
                    end
                end
                RUN: begin
                    cnt_r <= cnt_r + CNT_W'(1);
                    if (last) begin
                        state_r     <= DONE;
                        out_valid_r <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_valid_r && out_ready) begin
                        state_r     <= IDLE;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    cnt_r       <= {CNT_W{1'b0}};
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/seq_multiplier.sv
// WIDTH x WIDTH -> 2*WIDTH shift-add multiplier, one multiplier bit per clock, signed/unsigned at runtime.
// Define SEQMUL_EARLY_TERM_EN to stop as soon as the remaining multiplier bits are all zero.
module seq_multiplier
    import seq_mul_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic      clk,
    input  logic      rst_n,
    seq_mul_if.slave  bus
);
    localparam int PW = 2 * WIDTH;

    logic             accept_s;
    logic             run_s;
    logic             last_s;
    logic [WIDTH-1:0] a_mag_s;
    logic [WIDTH-1:0] b_mag_s;
    logic             neg_s;
    logic [PW-1:0]    acc_next_s;
    logic [PW-1:0]    acc_r;
    logic [PW-1:0]    mcand_r;
    logic [WIDTH-1:0] mplier_r;
    logic             neg_r;
    logic [PW-1:0]    result_r;

    seq_mul_ctrl #(
        .WIDTH (WIDTH)
    ) u_ctrl (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (bus.in_valid),
        .out_ready (bus.out_ready),
`ifdef SEQMUL_EARLY_TERM_EN
        .rest_zero ((mplier_r >> 1) == {WIDTH{1'b0}}),
`endif
        .in_ready  (bus.in_ready),
        .out_valid (bus.out_valid),
        .accept    (accept_s),
        .run       (run_s),
        .last      (last_s)
    );

    // Magnitudes are unsigned WIDTH bits so the most negative operand is still exact.
    always_comb begin
        a_mag_s = WIDTH'(abs_mag(MAG_MAX_W'($signed(bus.a)), bus.is_signed));
        b_mag_s = WIDTH'(abs_mag(MAG_MAX_W'($signed(bus.b)), bus.is_signed));
        neg_s   = bus.is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
        if (mplier_r[0]) begin
            acc_next_s = acc_r + mcand_r;
        end else begin
            acc_next_s = acc_r;
        end
    end

    // Operand capture on accept, one shift-add step per RUN cycle, sign fix-up into result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r    <= {PW{1'b0}};
            mcand_r  <= {PW{1'b0}};
            mplier_r <= {WIDTH{1'b0}};
            neg_r    <= 1'b0;
            result_r <= {PW{1'b0}};
        end else if (accept_s) begin
            acc_r    <= {PW{1'b0}};
            mcand_r  <= {{WIDTH{1'b0}}, a_mag_s};
            mplier_r <= b_mag_s;
            neg_r    <= neg_s;
        end else if (run_s) begin
            acc_r    <= acc_next_s;
            mcand_r  <= mcand_r << 1;
            mplier_r <= mplier_r >> 1;
            if (last_s) begin
                result_r <= neg_r ? ((~acc_next_s) + {{(PW-1){1'b0}}, 1'b1}) : acc_next_s;
            end
        end
    end

    assign bus.result = result_r;

endmodule
